alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the microprocessor datapath. It executes single-cycle arithmetic, logic and shift operations at any `WIDTH`, plus iterative multiply and divide. It adds carry-in operations and proper signed-overflow flags. Operands enter through a valid/ready handshake, and results with `{Z,C,S,V}` flags are held in output registers until the control unit takes them.

---
 rtl/alu_mc.sv | 215 +++++++++++++++++++++
 tb/tb_alu_mc.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus iterative shift-add
// multiply and restoring divide, with valid/ready operand and result handshakes.
module alu_mc #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [4:0]       mode,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic [3:0]       flags
);

    localparam logic [4:0] M_ADD = 5'd0,  M_SUB = 5'd1,  M_PASSA = 5'd2, M_PASSB = 5'd3;
    localparam logic [4:0] M_AND = 5'd4,  M_OR  = 5'd5,  M_XOR = 5'd6,   M_RSUB = 5'd7;
    localparam logic [4:0] M_INC = 5'd8,  M_DEC = 5'd9,  M_ROL = 5'd10,  M_ROR = 5'd11;
    localparam logic [4:0] M_SHL = 5'd12, M_SHR = 5'd13, M_SAR = 5'd14,  M_NEG = 5'd15;
    localparam logic [4:0] M_ADC = 5'd16, M_SBC = 5'd17, M_MUL = 5'd18,  M_DIV = 5'd19;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] work_hi_q, work_hi_d, work_lo_q, work_lo_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] res_q, res_d, res_hi_q, res_hi_d;
    logic [3:0]       flags_q, flags_d;

    logic             accept, is_mc;
    logic [SHW-1:0]   k;
    logic             kz;

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mc     = (mode == M_MUL) || (mode == M_DIV);
    assign k         = op1[SHW-1:0];
    assign kz        = (k == '0);
    assign out_valid = (state_q == S_DONE);
    assign res       = res_q;
    assign res_hi    = res_hi_q;
    assign flags     = flags_q;

    // All add/subtract modes share one adder: subtraction is x + ~y + 1, so C means "no borrow".
    logic [WIDTH-1:0] add_x, add_y;
    logic             add_ci;
    logic [WIDTH:0]   add_sum;
    logic             add_v;

    always_comb begin
        add_x  = op1;
        add_y  = op2;
        add_ci = 1'b0;
        case (mode)
            M_SUB:  begin add_y = ~op2; add_ci = 1'b1; end
            M_SBC:  begin add_y = ~op2; add_ci = cin;  end
            M_ADC:  add_ci = cin;
            M_RSUB: begin add_x = op2; add_y = ~op1; add_ci = 1'b1; end
            M_INC:  begin add_x = op2; add_y = '0;   add_ci = 1'b1; end
            M_DEC:  begin add_x = op2; add_y = '1;   add_ci = 1'b0; end
            M_NEG:  begin add_x = '0;  add_y = ~op2; add_ci = 1'b1; end
            default: ;
        endcase
    end

    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_ci};
    assign add_v   = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (add_sum[WIDTH-1] != add_x[WIDTH-1]);

    // Extra bit below/above B catches the last bit shifted out.
    logic [2*WIDTH-1:0] rol_w, ror_w;
    logic [WIDTH:0]     shl_w, shr_w, sar_w;
    assign rol_w = {op2, op2} << k;
    assign ror_w = {op2, op2} >> k;
    assign shl_w = {1'b0, op2} << k;
    assign shr_w = {op2, 1'b0} >> k;
    assign sar_w = $signed({op2, 1'b0}) >>> k;

    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v;

    always_comb begin
        sc_res = op1;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (mode)
            M_ADD, M_SUB, M_RSUB, M_INC, M_DEC, M_NEG, M_ADC, M_SBC: begin
                sc_res = add_sum[WIDTH-1:0];
                sc_c   = add_sum[WIDTH];
                sc_v   = add_v;
            end
            M_PASSA: sc_res = op1;
            M_PASSB: sc_res = op2;
            M_AND:   sc_res = op1 & op2;
            M_OR:    sc_res = op1 | op2;
            M_XOR:   sc_res = op1 ^ op2;
            M_ROL:   begin sc_res = rol_w[2*WIDTH-1:WIDTH]; sc_c = !kz && rol_w[WIDTH];   end
            M_ROR:   begin sc_res = ror_w[WIDTH-1:0];       sc_c = !kz && ror_w[WIDTH-1]; end
            M_SHL:   begin sc_res = shl_w[WIDTH-1:0]; sc_c = shl_w[WIDTH]; end
            M_SHR:   begin sc_res = shr_w[WIDTH:1];   sc_c = shr_w[0];     end
            M_SAR:   begin sc_res = sar_w[WIDTH:1];   sc_c = sar_w[0];     end
            default: ;
        endcase
    end

    // One iteration of multiply (work = {acc, multiplier}) or divide (work = {remainder, quotient}).
    logic [WIDTH:0]   mul_sum, div_sh, div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] step_hi, step_lo;

    assign mul_sum  = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign div_sh   = {work_hi_q, work_lo_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, b_q};
    assign div_ok   = ~div_diff[WIDTH];
    assign step_hi  = is_div_q ? (div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]) : mul_sum[WIDTH:1];
    assign step_lo  = is_div_q ? {work_lo_q[WIDTH-2:0], div_ok} : {mul_sum[0], work_lo_q[WIDTH-1:1]};

    logic             ld, ld_c, ld_v;
    logic [WIDTH-1:0] ld_res, ld_hi;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        is_div_d  = is_div_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        res_d     = res_q;
        res_hi_d  = res_hi_q;
        flags_d   = flags_q;
        ld        = 1'b0;
        ld_res    = '0;
        ld_hi     = '0;
        ld_c      = 1'b0;
        ld_v      = 1'b0;
        if (state_q == S_BUSY) begin
            work_hi_d = step_hi;
            work_lo_d = step_lo;
            cnt_d     = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                state_d = S_DONE;
                cnt_d   = '0;
                ld      = 1'b1;
                if (is_div_q && b_q == '0) begin
                    ld_res = '1;
                    ld_hi  = a_q;
                    ld_v   = 1'b1;
                end else begin
                    ld_res = step_lo;
                    ld_hi  = step_hi;
                    ld_c   = !is_div_q && (step_hi != '0);
                end
            end
        end else begin
            if (state_q == S_DONE && out_ready) state_d = S_IDLE;
            if (accept) begin
                if (is_mc) begin
                    state_d   = S_BUSY;
                    cnt_d     = SHW'(WIDTH - 1);
                    a_d       = op1;
                    b_d       = op2;
                    is_div_d  = (mode == M_DIV);
                    work_hi_d = '0;
                    work_lo_d = (mode == M_DIV) ? op1 : op2;
                end else begin
                    state_d = S_DONE;
                    ld      = 1'b1;
                    ld_res  = sc_res;
                    ld_c    = sc_c;
                    ld_v    = sc_v;
                end
            end
        end
        if (ld) begin
            res_d    = ld_res;
            res_hi_d = ld_hi;
            flags_d  = {ld_res == '0, ld_c, ld_res[WIDTH-1], ld_v};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            is_div_q  <= 1'b0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            res_q     <= '0;
            res_hi_q  <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            is_div_q  <= is_div_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            res_q     <= res_d;
            res_hi_q  <= res_hi_d;
            flags_q   <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at WIDTH=8 and WIDTH=16: directed vector table, handshake/reset
// sequences, and random operations checked against an arithmetic reference model.
module tb_alu_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        iv8, ir8, ov8, or8, cin8;
    logic [7:0]  a8, b8, r8, h8;
    logic [4:0]  m8;
    logic [3:0]  f8;
    logic        iv16, ir16, ov16, or16, cin16;
    logic [15:0] a16, b16, r16, h16;
    logic [4:0]  m16;
    logic [3:0]  f16;

    alu_mc #(.WIDTH(8)) u_alu8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .op1(a8), .op2(b8),
        .mode(m8), .cin(cin8), .out_valid(ov8), .out_ready(or8), .res(r8),
        .res_hi(h8), .flags(f8)
    );

    alu_mc #(.WIDTH(16)) u_alu16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .op1(a16), .op2(b16),
        .mode(m16), .cin(cin16), .out_valid(ov16), .out_ready(or16), .res(r16),
        .res_hi(h16), .flags(f16)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          w;
        int          mode;
        longint      a, b;
        bit          cin;
        longint      e_res, e_hi;
        logic [3:0]  e_f;
    } vec_t;
    vec_t vecs[$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    // Reference: plain integer arithmetic on the mode definitions.
    function automatic void model(input int w, input int mode, input longint a, input longint b,
                                  input bit cin, output longint r, output longint h,
                                  output logic [3:0] f);
        longint mask, half, sa, sb, sr, p;
        int     k;
        logic   c, v;
        bit     arith;
        mask  = (longint'(1) << w) - 1;
        half  = longint'(1) << (w - 1);
        k     = int'(a & longint'(w - 1));
        sa    = (a >= half) ? a - (mask + 1) : a;
        sb    = (b >= half) ? b - (mask + 1) : b;
        r = a; h = 0; c = 0; v = 0; sr = 0; arith = 0;
        case (mode)
            0:  begin r = a + b; c = (r > mask); sr = sa + sb; arith = 1; end
            1:  begin r = a - b; c = (a >= b); sr = sa - sb; arith = 1; end
            2:  r = a;
            3:  r = b;
            4:  r = a & b;
            5:  r = a | b;
            6:  r = a ^ b;
            7:  begin r = b - a; c = (b >= a); sr = sb - sa; arith = 1; end
            8:  begin r = b + 1; c = (r > mask); sr = sb + 1; arith = 1; end
            9:  begin r = b - 1; c = (b >= 1); sr = sb - 1; arith = 1; end
            10: begin r = (b << k) | (b >> (w - k)); if (k != 0) c = ((b >> (w - k)) & 1) != 0; end
            11: begin r = (b >> k) | (b << (w - k)); if (k != 0) c = ((b >> (k - 1)) & 1) != 0; end
            12: begin r = b << k; if (k != 0) c = ((b >> (w - k)) & 1) != 0; end
            13: begin r = b >> k; if (k != 0) c = ((b >> (k - 1)) & 1) != 0; end
            14: begin r = sb >>> k; if (k != 0) c = ((b >> (k - 1)) & 1) != 0; end
            15: begin r = -b; c = (b == 0); sr = -sb; arith = 1; end
            16: begin r = a + b + cin; c = (r > mask); sr = sa + sb + cin; arith = 1; end
            17: begin r = a - b - (!cin); c = (a >= b + (!cin)); sr = sa - sb - (!cin); arith = 1; end
            18: begin p = a * b; r = p; h = (p >> w) & mask; c = (h != 0); end
            19: begin
                if (b == 0) begin r = mask; h = a; v = 1; end
                else begin r = a / b; h = a % b; end
            end
            default: r = a;
        endcase
        r = r & mask;
        h = h & mask;
        if (arith) v = (sr < -half) || (sr > half - 1);
        f = {r == 0, c, ((r >> (w - 1)) & 1) != 0, v};
    endfunction

    task automatic drive(input int w, input bit v, input int mode, input longint a, input longint b, input bit cin);
        if (w == 8) begin
            iv8 = v; m8 = 5'(mode); a8 = 8'(a); b8 = 8'(b); cin8 = cin;
        end else begin
            iv16 = v; m16 = 5'(mode); a16 = 16'(a); b16 = 16'(b); cin16 = cin;
        end
    endtask

    task automatic sample(input int w, output logic ov, output logic ir, output longint r,
                          output longint h, output logic [3:0] f);
        if (w == 8) begin
            ov = ov8; ir = ir8; r = longint'(r8); h = longint'(h8); f = f8;
        end else begin
            ov = ov16; ir = ir16; r = longint'(r16); h = longint'(h16); f = f16;
        end
    endtask

    // One accepted operation with out_ready held high; checks latency, busy time and outputs.
    task automatic run_op(input string name, input int w, input int mode, input longint a, input longint b,
                          input bit cin, input longint e_res, input longint e_hi, input logic [3:0] e_f);
        logic ov, ir;
        longint r, h;
        logic [3:0] f;
        int lat, lowcnt;
        bit got, mc;
        mc = (mode == 18) || (mode == 19);
        @(negedge clk);
        drive(w, 1'b1, mode, a, b, cin);
        sample(w, ov, ir, r, h, f);
        check({name, ".in_ready"}, ir, 1);
        @(posedge clk);
        #1 drive(w, 1'b0, $urandom_range(0, 31), $urandom, $urandom, 1'($urandom_range(0, 1)));
        lat = 0; lowcnt = 0; got = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            sample(w, ov, ir, r, h, f);
            if (ov === 1'b1) begin
                got = 1; lat = i;
                break;
            end
            if (ir === 1'b0) lowcnt++;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s.timeout actual=no_out_valid expected=out_valid", name);
        end else begin
            check({name, ".latency"}, lat, mc ? w + 1 : 1);
            if (mc) check({name, ".busy_cycles"}, lowcnt, w);
            check({name, ".res"}, r, e_res);
            check({name, ".res_hi"}, h, e_hi);
            check({name, ".flags"}, f, e_f);
        end
    endtask

    task automatic add_vec(input string name, input int w, input int mode, input longint a, input longint b,
                           input bit cin, input longint e_res, input longint e_hi, input logic [3:0] e_f);
        vec_t v;
        v.name = name; v.w = w; v.mode = mode; v.a = a; v.b = b; v.cin = cin;
        v.e_res = e_res; v.e_hi = e_hi; v.e_f = e_f;
        vecs.push_back(v);
    endtask

    function automatic longint rand_operand(input int w);
        longint mask;
        mask = (longint'(1) << w) - 1;
        case ($urandom_range(0, 5))
            0: return 0;
            1: return mask;
            2: return longint'(1) << (w - 1);
            3: return (longint'(1) << (w - 1)) - 1;
            default: return longint'($urandom) & mask;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    logic [7:0] bb_a [3];
    logic [7:0] bb_b [3];
    logic [7:0] bb_res [3];
    logic [3:0] bb_f [3];
    int         bb_mode [3];

    initial begin
        logic ov, ir;
        longint r, h;
        logic [3:0] f;
        longint er, eh;
        logic [3:0] ef;
        int ovcnt;

        rst = 1'b1;
        or8 = 1'b1; or16 = 1'b1;
        drive(8, 1'b0, 0, 0, 0, 1'b0);
        drive(16, 1'b0, 0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst.in_ready", ir8, 1);
        check("rst.out_valid", ov8, 0);
        check("rst.res", r8, 0);
        check("rst.res_hi", h8, 0);
        check("rst.flags", f8, 0);
        check("rst.in_ready16", ir16, 1);
        check("rst.out_valid16", ov16, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst.out_valid", ov8, 0);

        add_vec("add_ovf",   8,  0, 'h7F, 'h01, 0, 'h80, 0, 4'b0011);
        add_vec("add_carry", 8,  0, 'hFF, 'h01, 0, 'h00, 0, 4'b1100);
        add_vec("sub_neg",   8,  1, 'h05, 'h07, 0, 'hFE, 0, 4'b0010);
        add_vec("adc_chain", 16, 16, 'hFFFF, 'h0000, 1, 'h0000, 0, 4'b1100);
        add_vec("sbc_chain", 16, 17, 'h0000, 'h0000, 0, 'hFFFF, 0, 4'b0010);
        add_vec("sbc_ovf",   16, 17, 'h8000, 'h0001, 1, 'h7FFF, 0, 4'b0101);
        add_vec("adc_ovf",   16, 16, 'h7FFF, 'h0000, 1, 'h8000, 0, 4'b0011);
        add_vec("rol3",      8, 10, 'h03, 'h96, 0, 'hB4, 0, 4'b0010);
        add_vec("ror3",      8, 11, 'h03, 'h96, 0, 'hD2, 0, 4'b0110);
        add_vec("shr3",      8, 13, 'h03, 'h96, 0, 'h12, 0, 4'b0100);
        add_vec("sar3",      8, 14, 'h03, 'h96, 0, 'hF2, 0, 4'b0110);
        add_vec("shl_k0",    8, 12, 'h08, 'h96, 0, 'h96, 0, 4'b0010);
        add_vec("mul_ff",    8, 18, 'hFF, 'hFF, 0, 'h01, 'hFE, 4'b0100);
        add_vec("div_200_7", 8, 19, 200, 7, 0, 28, 4, 4'b0000);
        add_vec("div_zero",  8, 19, 9, 0, 0, 'hFF, 9, 4'b0011);
        add_vec("neg_min",   8, 15, 'h00, 'h80, 0, 'h80, 0, 4'b0011);
        add_vec("neg_zero",  8, 15, 'h00, 'h00, 0, 'h00, 0, 4'b1100);
        add_vec("inc_wrap",  8,  8, 'h00, 'hFF, 0, 'h00, 0, 4'b1100);
        add_vec("dec_zero",  8,  9, 'h00, 'h00, 0, 'hFF, 0, 4'b0010);
        add_vec("rsub",      8,  7, 'h03, 'h05, 0, 'h02, 0, 4'b0100);
        add_vec("reserved",  8, 25, 'h5A, 'h11, 0, 'h5A, 0, 4'b0000);
        add_vec("pass_b",    8,  3, 'h01, 'h00, 0, 'h00, 0, 4'b1000);
        add_vec("mul16",     16, 18, 'h1234, 'h0010, 0, 'h2340, 'h0001, 4'b0100);
        add_vec("div16",     16, 19, 1000, 3, 0, 333, 1, 4'b0000);
        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].w, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].e_res, vecs[i].e_hi, vecs[i].e_f);

        // Back-to-back single-cycle ops: one result per clock.
        bb_mode = '{0, 6, 8};
        bb_a    = '{8'h10, 8'hFF, 8'h00};
        bb_b    = '{8'h20, 8'h0F, 8'h7F};
        bb_res  = '{8'h30, 8'hF0, 8'h80};
        bb_f    = '{4'b0000, 4'b0010, 4'b0011};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("b2b.out_valid", ov8, 1);
                check("b2b.res", r8, bb_res[i-1]);
                check("b2b.flags", f8, bb_f[i-1]);
            end
            if (i < 3) begin
                check("b2b.in_ready", ir8, 1);
                drive(8, 1'b1, bb_mode[i], bb_a[i], bb_b[i], 1'b0);
            end else begin
                drive(8, 1'b0, 0, 0, 0, 1'b0);
            end
        end
        @(negedge clk);
        check("b2b.drain", ov8, 0);

        // Output stall: result holds, in_ready low, pending op waits.
        or8 = 1'b0;
        drive(8, 1'b1, 1, 'h05, 'h07, 1'b0);
        @(posedge clk);
        #1 drive(8, 1'b1, 4, 'hF0, 'h3C, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold.out_valid", ov8, 1);
            check("hold.res", r8, 'hFE);
            check("hold.flags", f8, 4'b0010);
            check("hold.in_ready", ir8, 0);
        end
        or8 = 1'b1;
        @(posedge clk);
        #1 drive(8, 1'b0, 0, 0, 0, 1'b0);
        @(negedge clk);
        check("swap.out_valid", ov8, 1);
        check("swap.res", r8, 'h30);
        check("swap.flags", f8, 4'b0000);
        @(negedge clk);

        // Asynchronous reset three cycles into a multiply.
        drive(8, 1'b1, 18, 'hFF, 'hFF, 1'b0);
        @(posedge clk);
        #1 drive(8, 1'b0, 0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("mid_mul.in_ready", ir8, 0);
        check("mid_mul.res_held", r8, 'h30);
        #1 rst = 1'b1;
        #1;
        check("async_rst.out_valid", ov8, 0);
        check("async_rst.in_ready", ir8, 1);
        check("async_rst.res", r8, 0);
        check("async_rst.res_hi", h8, 0);
        check("async_rst.flags", f8, 0);
        @(negedge clk);
        rst = 1'b0;
        ovcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ov8 !== 1'b0) ovcnt++;
        end
        check("post_abort.stale_valid", ovcnt, 0);
        check("post_abort.in_ready", ir8, 1);
        run_op("post_abort_div", 8, 19, 200, 7, 1'b0, 28, 4, 4'b0000);

        // Random operations against the reference model.
        for (int n = 0; n < 210; n++) begin
            int w, mode;
            longint a, b;
            bit c;
            w    = (n < 150) ? 8 : 16;
            mode = $urandom_range(0, 31);
            a    = rand_operand(w);
            b    = rand_operand(w);
            c    = 1'($urandom_range(0, 1));
            model(w, mode, a, b, c, er, eh, ef);
            run_op($sformatf("rand%0d_m%0d", n, mode), w, mode, a, b, c, er, eh, ef);
        end

        sample(8, ov, ir, r, h, f);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
